// File: rtl/threshold_engine.sv
// threshold_engine: start-triggered per-channel thresholding of a V_SIZE x H_SIZE frame with foreground count
// Ports: clk/reset (sync, active-high); start/abort control a pass; mode/any_mode/threshold/color_0/color_1
// are latched at start; rd_pixel/addr_pixel/pixel_val/pixel_in form the read handshake; wr_pixel/addr_out/
// pixel_out carry results; busy/done/ones_count report pass status.
module threshold_engine #(
    parameter int V_SIZE = 4,
    parameter int H_SIZE = 4,
    parameter int CH     = 3,
    parameter int DW     = 8,
    parameter int AW     = (V_SIZE * H_SIZE > 1) ? $clog2(V_SIZE * H_SIZE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             any_mode,
    input  logic [CH*DW-1:0] threshold,
    input  logic [CH*DW-1:0] color_0,
    input  logic [CH*DW-1:0] color_1,
    output logic             rd_pixel,
    output logic [AW-1:0]    addr_pixel,
    input  logic             pixel_val,
    input  logic [CH*DW-1:0] pixel_in,
    output logic             wr_pixel,
    output logic [AW-1:0]    addr_out,
    output logic [CH*DW-1:0] pixel_out,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      ones_count
);
    localparam logic [AW-1:0] LAST = AW'(V_SIZE * H_SIZE - 1);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] mode_q;
    logic any_q;
    logic [CH*DW-1:0] thr_q, c0_q, c1_q;
    logic rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d, load;
    logic [AW-1:0] addr_q, addr_d, aout_q, aout_d;
    logic [CH*DW-1:0] pout_q, pout_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [CH-1:0] pass;
    logic [CH*DW-1:0] trunc, tozero, result;
    logic fg;
    // trunc = min(pixel, threshold): the pass bit already says which one is smaller
    always_comb begin
        pass = '0;
        trunc = '0;
        tozero = '0;
        for (int c = 0; c < CH; c++) begin
            pass[c] = pixel_in[c*DW +: DW] >= thr_q[c*DW +: DW];
            trunc[c*DW +: DW] = pass[c] ? thr_q[c*DW +: DW] : pixel_in[c*DW +: DW];
            tozero[c*DW +: DW] = pass[c] ? pixel_in[c*DW +: DW] : '0;
        end
        fg = any_q ? |pass : &pass;
        result = mode_q == 2'd0 ? (fg ? c1_q : c0_q) :
                 mode_q == 2'd1 ? (fg ? c0_q : c1_q) :
                 mode_q == 2'd2 ? trunc : tozero;
    end
    always_comb begin
        state_d = state_q;
        rd_d = 1'b0;
        wr_d = 1'b0;
        addr_d = addr_q;
        aout_d = aout_q;
        pout_d = pout_q;
        busy_d = busy_q;
        done_d = done_q;
        cnt_d = cnt_q;
        load = 1'b0;
        case (state_q)
            WAIT: begin
                // abort wins over a same-cycle pixel_val: nothing is written or counted
                if (abort) begin
                    state_d = IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b0;
                    addr_d = '0;
                end else if (pixel_val) begin
                    wr_d = 1'b1;
                    aout_d = addr_q;
                    pout_d = result;
                    cnt_d = cnt_q + (AW + 1)'(fg);
                    if (addr_q == LAST) begin
                        state_d = DONE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        addr_d = '0;
                    end else begin
                        rd_d = 1'b1;
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = WAIT;
                    rd_d = 1'b1;
                    addr_d = '0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    cnt_d = '0;
                    load = 1'b1;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            addr_q <= '0;
            aout_q <= '0;
            pout_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q <= '0;
            mode_q <= '0;
            any_q <= 1'b0;
            thr_q <= '0;
            c0_q <= '0;
            c1_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            addr_q <= addr_d;
            aout_q <= aout_d;
            pout_q <= pout_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q <= cnt_d;
            if (load) begin
                mode_q <= mode;
                any_q <= any_mode;
                thr_q <= threshold;
                c0_q <= color_0;
                c1_q <= color_1;
            end
        end
    end
    assign rd_pixel = rd_q;
    assign addr_pixel = addr_q;
    assign wr_pixel = wr_q;
    assign addr_out = aout_q;
    assign pixel_out = pout_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ones_count = cnt_q;
endmodule

// File: tb/tb_threshold_engine.sv
// tb_threshold_engine: directed frames with hand-computed writes, counts and timing for threshold_engine
module tb_threshold_engine;
    localparam int AW = 2;
    logic clk = 1'b0;
    logic reset, start, abort, any_mode, pixel_val, rd_pixel, wr_pixel, busy, done;
    logic [1:0] mode;
    logic [23:0] threshold, color_0, color_1, pixel_in, pixel_out;
    logic [AW-1:0] addr_pixel, addr_out;
    logic [AW:0] ones_count;
    logic [23:0] mem [4];
    logic [23:0] exp_w [4];
    int checks = 0;
    int errors = 0;

    threshold_engine #(.V_SIZE(2), .H_SIZE(2), .CH(3), .DW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .any_mode(any_mode), .threshold(threshold), .color_0(color_0), .color_1(color_1),
        .rd_pixel(rd_pixel), .addr_pixel(addr_pixel), .pixel_val(pixel_val), .pixel_in(pixel_in),
        .wr_pixel(wr_pixel), .addr_out(addr_out), .pixel_out(pixel_out), .busy(busy),
        .done(done), .ones_count(ones_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic a, input logic [23:0] t, input logic [23:0] c0, input logic [23:0] c1);
        mode = m;
        any_mode = a;
        threshold = t;
        color_0 = c0;
        color_1 = c1;
    endtask

    task automatic set_frame(input logic [23:0] m0, m1, m2, m3, input logic [23:0] e0, e1, e2, e3);
        mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
        exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    endtask

    // lat: negedges between seeing rd_pixel and driving pixel_val; ab: address to abort on (-1 none)
    task automatic frame(input int lat, input int ab, input int ones, input int done_cyc);
        int cyc, cd, nw, nr, ra;
        bit prev_rd, ab_pend, fin;
        cd = -1; nw = 0; nr = 0; ra = 0; prev_rd = 0; ab_pend = 0; fin = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("start_rd", 32'(rd_pixel), 1);
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_ones", 32'(ones_count), 0);
        mode = ~mode;
        any_mode = ~any_mode;
        threshold = ~threshold;
        color_0 = ~color_0;
        color_1 = ~color_1;
        while (!fin && cyc < 200) begin
            if (ab_pend) begin
                check("ab_busy", 32'(busy), 0);
                check("ab_done", 32'(done), 0);
                check("ab_rd", 32'(rd_pixel), 0);
                check("ab_wr", 32'(wr_pixel), 0);
                check("ab_addr", 32'(addr_pixel), 0);
                check("ab_ones", 32'(ones_count), 32'(ones));
                check("ab_writes", 32'(nw), 32'(ab));
                abort = 1'b0;
                pixel_val = 1'b0;
                start = 1'b0;
                return;
            end
            if (wr_pixel) begin
                check("wr_addr", 32'(addr_out), 32'(nw));
                check("wr_data", 32'(pixel_out), 32'(exp_w[nw & 3]));
                nw++;
            end
            if (rd_pixel) begin
                check("rd_pulse", 32'(prev_rd), 0);
                check("rd_addr", 32'(addr_pixel), 32'(nr));
                ra = int'(addr_pixel);
                nr++;
                cd = lat;
            end
            prev_rd = rd_pixel;
            if (done) begin
                fin = 1;
            end else begin
                start = (cyc == 2);
                if (cd == 0) begin
                    pixel_val = 1'b1;
                    pixel_in = mem[ra];
                    abort = (ra == ab);
                    ab_pend = abort;
                    cd = -1;
                end else begin
                    pixel_val = 1'b0;
                    pixel_in = 24'($urandom);
                    if (cd > 0) cd--;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        pixel_val = 1'b0;
        check("done_cyc", 32'(cyc), 32'(done_cyc));
        check("end_ones", 32'(ones_count), 32'(ones));
        check("end_busy", 32'(busy), 0);
        check("end_addr", 32'(addr_pixel), 0);
        check("end_writes", 32'(nw), 4);
    endtask

    initial begin
        bit found;
        reset = 1'b1; start = 1'b0; abort = 1'b0; pixel_val = 1'b0; pixel_in = '0;
        cfg(2'd0, 1'b0, 24'h0, 24'h0, 24'h0);
        repeat (2) @(negedge clk);
        check("rst_rd", 32'(rd_pixel), 0);
        check("rst_addr", 32'(addr_pixel), 0);
        check("rst_wr", 32'(wr_pixel), 0);
        check("rst_aout", 32'(addr_out), 0);
        check("rst_pout", 32'(pixel_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ones", 32'(ones_count), 0);
        reset = 1'b0;
        @(negedge clk);
        // binary, all channels
        set_frame(24'h808080, 24'h7F8080, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000);
        cfg(2'd0, 1'b0, 24'h808080, 24'h000000, 24'hFFFFFF);
        frame(1, -1, 2, 9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("done_abort_done", 32'(done), 1);
        check("done_abort_ones", 32'(ones_count), 2);
        // invert, any channel
        set_frame(24'h808080, 24'h7F8080, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF);
        cfg(2'd1, 1'b1, 24'h808080, 24'h000000, 24'hFFFFFF);
        frame(1, -1, 3, 9);
        // truncate, all channels
        set_frame(24'h7F2090, 24'h000000, 24'hFFFFFF, 24'h405060, 24'h402060, 24'h000000, 24'h405060, 24'h405060);
        cfg(2'd2, 1'b0, 24'h405060, 24'h123456, 24'hABCDEF);
        frame(1, -1, 2, 9);
        // to-zero, any channel
        set_frame(24'h7F2090, 24'h000000, 24'hFFFFFF, 24'h405060, 24'h7F0090, 24'h000000, 24'hFFFFFF, 24'h405060);
        cfg(2'd3, 1'b1, 24'h405060, 24'h123456, 24'hABCDEF);
        frame(1, -1, 3, 9);
        // slow memory: 3-cycle read latency
        set_frame(24'h808080, 24'h7F8080, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000);
        cfg(2'd0, 1'b0, 24'h808080, 24'h000000, 24'hFFFFFF);
        frame(3, -1, 2, 17);
        // abort together with pixel_val on address 2
        cfg(2'd0, 1'b0, 24'h808080, 24'h000000, 24'hFFFFFF);
        frame(1, 2, 1, 0);
        pixel_val = 1'b1;
        pixel_in = 24'hFFFFFF;
        repeat (2) begin
            @(negedge clk);
            check("idle_val_wr", 32'(wr_pixel), 0);
            check("idle_val_rd", 32'(rd_pixel), 0);
            check("idle_val_busy", 32'(busy), 0);
        end
        pixel_val = 1'b0;
        cfg(2'd0, 1'b0, 24'h808080, 24'h000000, 24'hFFFFFF);
        frame(1, -1, 2, 9);
        // reset while waiting on address 1, zero-latency memory
        cfg(2'd0, 1'b0, 24'h808080, 24'h000000, 24'hFFFFFF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rd_pixel && addr_pixel == 2'd1) begin
                found = 1;
            end else begin
                pixel_val = rd_pixel;
                pixel_in = mem[addr_pixel];
                @(negedge clk);
            end
        end
        check("rst_mid_found", 32'(found), 1);
        reset = 1'b1;
        pixel_val = 1'b1;
        pixel_in = mem[1];
        @(negedge clk);
        check("rst_mid_rd", 32'(rd_pixel), 0);
        check("rst_mid_addr", 32'(addr_pixel), 0);
        check("rst_mid_wr", 32'(wr_pixel), 0);
        check("rst_mid_aout", 32'(addr_out), 0);
        check("rst_mid_pout", 32'(pixel_out), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(done), 0);
        check("rst_mid_ones", 32'(ones_count), 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rd", 32'(rd_pixel), 0);
            check("post_rst_wr", 32'(wr_pixel), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        pixel_val = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
